// File: rtl/fmul_issue.sv
// ---------------------------------------------------------------------------
// fmul_issue
//
// Issue/staging stage that sits directly in front of the combinational
// single-precision multiplier (fmul). A request from FPU dispatch is latched
// into operand registers that drive fmul and are held constant for LATENCY
// cycles. Downstream timing can therefore treat fmul as a multicycle path.
// When the hold expires, fmul's output is captured together with the
// destination tag and offered to writeback.
//
// Parameters
//   LATENCY  cycles the fmul inputs are held before y is sampled (1..15)
//   TAGW     width of the destination-register tag
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   flush      synchronous flush, drops any in-flight or held op
//   in_valid   request valid from dispatch
//   in_ready   stage accepts a request this cycle
//   in_x1      operand 1 (IEEE-754 single)
//   in_x2      operand 2 (IEEE-754 single)
//   in_tag     destination tag of the request
//   mul_x1     registered operand 1 to fmul
//   mul_x2     registered operand 2 to fmul
//   mul_y      product from fmul
//   out_valid  registered result valid to writeback
//   out_ready  writeback accepts the result
//   out_y      registered result
//   out_tag    registered tag of the result
//   busy       stage is not idle
// ---------------------------------------------------------------------------
module fmul_issue #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAGW    = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x1,
  input  logic [31:0]     in_x2,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     mul_x1,
  output logic [31:0]     mul_x2,
  input  logic [31:0]     mul_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  // Zero would mean sampling fmul in the same edge its inputs change, and
  // the counter is sized for at most four bits.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("fmul_issue: LATENCY must be in 1..15");
  end

  // Guarded so an illegal LATENCY=0 still yields a legal width while the
  // elaboration error above is reported.
  localparam int unsigned CNTW = ($clog2(LATENCY + 1) > 0) ? $clog2(LATENCY + 1) : 1;

  // The first EXEC cycle is already one of the LATENCY hold cycles.
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [CNTW-1:0]   cnt_q,       cnt_d;
  logic [31:0]       mul_x1_q,    mul_x1_d;
  logic [31:0]       mul_x2_q,    mul_x2_d;
  logic [TAGW-1:0]   tag_q,       tag_d;
  logic [31:0]       out_y_q,     out_y_d;
  logic [TAGW-1:0]   out_tag_q,   out_tag_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;

  // in_ready depends only on state, out_ready and flush. It must never look
  // at in_valid, otherwise dispatch and this stage form a combinational loop.
  // In DONE a new op can only be taken when the held result retires on the
  // same edge, since the output registers cannot hold two results.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        DONE:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  // Next-state logic. Operand and tag registers only load on accept so fmul
  // sees stable inputs for the whole EXEC period. Flush overrides the state
  // machine but deliberately leaves the data registers alone: once
  // out_valid is low their contents are ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_x1_d    = mul_x1_q;
    mul_x2_d    = mul_x2_q;
    tag_d       = tag_q;
    out_y_d     = out_y_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mul_x1_d = in_x1;
          mul_x2_d = in_x2;
          tag_d    = in_tag;
          cnt_d    = CNT_INIT;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          out_y_d     = mul_y;
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            mul_x1_d = in_x1;
            mul_x2_d = in_x2;
            tag_d    = in_tag;
            cnt_d    = CNT_INIT;
            state_d  = EXEC;
          end else begin
            state_d  = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  // State and datapath registers. Reset clears everything so a reset in the
  // middle of an operation leaves no trace on the outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_x1_q    <= '0;
      mul_x2_q    <= '0;
      tag_q       <= '0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_x1_q    <= mul_x1_d;
      mul_x2_q    <= mul_x2_d;
      tag_q       <= tag_d;
      out_y_q     <= out_y_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mul_x1    = mul_x1_q;
  assign mul_x2    = mul_x2_q;
  assign out_y     = out_y_q;
  assign out_tag   = out_tag_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

  // A result is offered exactly while the FSM sits in DONE.
  a_valid_matches_done: assert property (
    @(posedge clk) disable iff (!rstn)
    out_valid_q == (state_q == DONE)
  );

  // fmul is timed as a multicycle path, so its inputs may not move until
  // the product has been captured.
  a_operands_stable: assert property (
    @(posedge clk) disable iff (!rstn)
    (state_q == EXEC) |=> ($stable(mul_x1_q) && $stable(mul_x2_q))
  );

  // A held result may not change while writeback is stalling.
  a_result_held: assert property (
    @(posedge clk) disable iff (!rstn)
    (out_valid_q && !out_ready && !flush) |=>
      (out_valid_q && $stable(out_y_q) && $stable(out_tag_q))
  );

endmodule

// File: tb/tb_fmul_issue.sv
// ---------------------------------------------------------------------------
// tb_fmul_issue
//
// Self-checking bench for fmul_issue. Two instances are built: one with
// LATENCY=2 for the main scenarios and one with LATENCY=1 for the
// short-latency build. Each drives a behavioural stand-in for fmul whose
// output only becomes correct once its inputs have been stable for LATENCY
// cycles. Before that it returns a poison value, so an early sample of
// mul_y shows up as a wrong result.
// ---------------------------------------------------------------------------
module tb_fmul_issue;

  localparam int unsigned LAT   = 2;
  localparam int unsigned LAT_B = 1;
  localparam int unsigned TAGW  = 6;
  localparam logic [31:0] POISON = 32'hDEADBEEF;

  typedef struct {
    logic [31:0]     x1;
    logic [31:0]     x2;
    logic [TAGW-1:0] tag;
    logic [31:0]     y;
  } opVec_t;

  logic            clk = 1'b0;
  logic            rstn;

  logic            flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]     in_x1, in_x2, mul_x1, mul_x2, mul_y, out_y;
  logic [TAGW-1:0] in_tag, out_tag;

  logic            flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [31:0]     in_x1_b, in_x2_b, mul_x1_b, mul_x2_b, mul_y_b, out_y_b;
  logic [TAGW-1:0] in_tag_b, out_tag_b;

  int nChecks = 0;
  int nFails  = 0;

  int          ageA = 0;
  int          ageB = 0;
  logic [31:0] lastA1 = '0, lastA2 = '0, lastB1 = '0, lastB2 = '0;

  opVec_t vecs [6];

  always #5 clk = ~clk;

  fmul_issue #(.LATENCY(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  fmul_issue #(.LATENCY(LAT_B), .TAGW(TAGW)) dut_b (
    .clk(clk), .rstn(rstn), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_x1(in_x1_b), .in_x2(in_x2_b), .in_tag(in_tag_b),
    .mul_x1(mul_x1_b), .mul_x2(mul_x2_b), .mul_y(mul_y_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_y(out_y_b), .out_tag(out_tag_b), .busy(busy_b)
  );

  // Truncating single-precision multiply covering zeros, normals and
  // overflow to infinity; underflow flushes to signed zero.
  function automatic logic [31:0] fmulModel(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  // Age of the fmul inputs, counted in negedges since they last changed.
  always @(negedge clk) begin
    if (mul_x1 !== lastA1 || mul_x2 !== lastA2) begin
      lastA1 = mul_x1;
      lastA2 = mul_x2;
      ageA   = 1;
    end else if (ageA < 1000) begin
      ageA = ageA + 1;
    end
    if (mul_x1_b !== lastB1 || mul_x2_b !== lastB2) begin
      lastB1 = mul_x1_b;
      lastB2 = mul_x2_b;
      ageB   = 1;
    end else if (ageB < 1000) begin
      ageB = ageB + 1;
    end
  end

  assign mul_y   = (ageA >= int'(LAT))   ? fmulModel(mul_x1, mul_x2)     : POISON;
  assign mul_y_b = (ageB >= int'(LAT_B)) ? fmulModel(mul_x1_b, mul_x2_b) : POISON;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAGW-1:0] t, input logic ordy, input logic fl);
    in_valid  = iv;
    in_x1     = a;
    in_x2     = b;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with out_ready held high: accept, wait for
  // the result within a bounded number of edges, check it, then retire it.
  task automatic runOp(input opVec_t v, input string name);
    int edges;
    applyStimulus(1'b1, v.x1, v.x2, v.tag, 1'b1, 1'b0);
    #1;
    checkOutput({name, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    checkOutput({name, " latency"}, 32'(edges), 32'(LAT));
    checkOutput({name, " out_y"}, out_y, v.y);
    checkOutput({name, " out_tag"}, 32'(out_tag), 32'(v.tag));
    step();
    checkOutput({name, " retired"}, 32'(out_valid), 32'd0);
    checkOutput({name, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{x1: 32'h40000000, x2: 32'h40400000, tag: 6'd5,  y: 32'h40C00000};
    vecs[1] = '{x1: 32'h3FC00000, x2: 32'h3FC00000, tag: 6'd1,  y: 32'h40100000};
    vecs[2] = '{x1: 32'hBF800000, x2: 32'h3F800000, tag: 6'd2,  y: 32'hBF800000};
    vecs[3] = '{x1: 32'h00000000, x2: 32'h40000000, tag: 6'd12, y: 32'h00000000};
    vecs[4] = '{x1: 32'h7F000000, x2: 32'h7F000000, tag: 6'd63, y: 32'h7F800000};
    vecs[5] = '{x1: 32'h80000000, x2: 32'h3F800000, tag: 6'd33, y: 32'h80000000};

    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    flush_b = 1'b0; in_valid_b = 1'b0; in_x1_b = '0; in_x2_b = '0;
    in_tag_b = '0; out_ready_b = 1'b0;
    rstn = 1'b0;

    // Reset state
    #2;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_y", out_y, 32'd0);
    checkOutput("reset out_tag", 32'(out_tag), 32'd0);
    checkOutput("reset mul_x1", mul_x1, 32'd0);
    checkOutput("reset mul_x2", mul_x2, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    step();
    step();
    rstn = 1'b1;
    #1;
    checkOutput("idle in_ready", 32'(in_ready), 32'd1);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      runOp(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back with a writeback stall
    applyStimulus(1'b1, 32'h3FC00000, 32'h3FC00000, 6'd1, 1'b0, 1'b0);
    step();
    checkOutput("stall busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 32'hBF800000, 32'h3F800000, 6'd2, 1'b0, 1'b0);
    #1;
    checkOutput("stall exec in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("stall edge1 out_valid", 32'(out_valid), 32'd0);
    checkOutput("stall edge1 in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("stall done out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall done out_y", out_y, 32'h40100000);
    checkOutput("stall done out_tag", 32'(out_tag), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("hold%0d out_y", i), out_y, 32'h40100000);
      checkOutput($sformatf("hold%0d out_tag", i), 32'(out_tag), 32'd1);
      checkOutput($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("op2 accepted out_valid", 32'(out_valid), 32'd0);
    checkOutput("op2 accepted busy", 32'(busy), 32'd1);
    checkOutput("op2 accepted mul_x1", mul_x1, 32'hBF800000);
    step();
    checkOutput("op2 edge1 out_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("op2 out_valid", 32'(out_valid), 32'd1);
    checkOutput("op2 out_y", out_y, 32'hBF800000);
    checkOutput("op2 out_tag", 32'(out_tag), 32'd2);
    step();
    checkOutput("op2 retired", 32'(out_valid), 32'd0);
    checkOutput("op2 idle", 32'(busy), 32'd0);

    // Flush while in EXEC with cnt=1
    applyStimulus(1'b1, 32'h40400000, 32'h40400000, 6'd7, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1);
    checkOutput("flush exec busy before", 32'(busy), 32'd1);
    step();
    flush = 1'b0;
    checkOutput("flush exec busy", 32'(busy), 32'd0);
    checkOutput("flush exec out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("flush exec quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // Flush while holding a result, with a competing request
    applyStimulus(1'b1, 32'h40800000, 32'h40000000, 6'd9, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    step();
    checkOutput("flush done out_valid", 32'(out_valid), 32'd1);
    checkOutput("flush done out_y", out_y, 32'h41000000);
    checkOutput("flush done out_tag", 32'(out_tag), 32'd9);
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 6'd11, 1'b0, 1'b1);
    #1;
    checkOutput("flush cycle in_ready", 32'(in_ready), 32'd0);
    step();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("flush done dropped", 32'(out_valid), 32'd0);
    checkOutput("flush done idle", 32'(busy), 32'd0);
    checkOutput("flush not accepted", mul_x1, 32'h40800000);

    // Asynchronous reset in the middle of EXEC
    applyStimulus(1'b1, 32'h40000000, 32'h40400000, 6'd5, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("async out_valid", 32'(out_valid), 32'd0);
    checkOutput("async out_y", out_y, 32'd0);
    checkOutput("async busy", 32'(busy), 32'd0);
    checkOutput("async mul_x1", mul_x1, 32'd0);
    #2;
    rstn = 1'b1;
    runOp(vecs[0], "post-reset");

    // LATENCY=1 instance: first result after one edge, then one result
    // every two cycles with in_valid and out_ready held high.
    in_valid_b = 1'b1; in_x1_b = 32'h40000000; in_x2_b = 32'h40400000;
    in_tag_b = 6'd3; out_ready_b = 1'b1;
    step();
    checkOutput("lat1 accept out_valid", 32'(out_valid_b), 32'd0);
    checkOutput("lat1 accept busy", 32'(busy_b), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      checkOutput($sformatf("lat1 edge%0d out_valid", i), 32'(out_valid_b), 32'(i % 2));
      if (i % 2 == 1) begin
        checkOutput($sformatf("lat1 edge%0d out_y", i), out_y_b, 32'h40C00000);
        checkOutput($sformatf("lat1 edge%0d out_tag", i), 32'(out_tag_b), 32'd3);
      end
    end
    in_valid_b = 1'b0;
    step();
    step();
    checkOutput("lat1 drained", 32'(busy_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fmul_issue.md
Name: fmul_issue

Overview:
- Issue/staging stage directly upstream of the combinational fmul.
- Accepts FP multiply requests from the FPU dispatch over a valid/ready handshake and holds operands stable in registers for LATENCY cycles, so fmul can be constrained as a multicycle path.
- Captures fmul's result and presents it with its destination tag to writeback over a second valid/ready handshake.

Parameters:
- LATENCY, 2, number of cycles fmul inputs are held stable before its output is sampled; legal range 1..15; 0 is illegal (elaboration assertion).
- TAGW, 6, width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; drops any in-flight or held op.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request this cycle.
- in_x1  in  32  operand 1, IEEE-754 single.
- in_x2  in  32  operand 2, IEEE-754 single.
- in_tag  in  TAGW  destination tag.
- mul_x1  out  32  to fmul x1; registered.
- mul_x2  out  32  to fmul x2; registered.
- mul_y  in  32  from fmul y.
- out_valid  out  1  result valid; registered.
- out_ready  in  1  writeback accepts result.
- out_y  out  32  result; registered.
- out_tag  out  TAGW  tag of result; registered.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE, cnt=0, out_valid=0.
  - out_y, out_tag, mul_x1, mul_x2 all 0.
  - Reset mid-operation abandons the op with no output.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch in_x1/in_x2 into mul_x1/mul_x2, latch in_tag, cnt<=LATENCY-1, go EXEC.
  - EXEC: in_ready=0; mul_x1/mul_x2 held constant. If cnt!=0, cnt<=cnt-1. If cnt==0, out_y<=mul_y, out_tag<=op tag, out_valid<=1, go DONE.
  - DONE: out_valid=1; out_y/out_tag held stable until out_ready.
    - in_ready = out_ready (combinational from out_ready and state only, never from in_valid).
    - out_ready & in_valid: result retires and new op latched in the same edge; go EXEC; out_valid<=0.
    - out_ready & !in_valid: go IDLE; out_valid<=0.
    - !out_ready: stay in DONE; holding out_valid with stable data is required.
- flush (synchronous, highest priority below reset):
  - Next state IDLE, out_valid<=0, cnt<=0.
  - in_ready is forced 0 while flush=1, so no op is accepted in the flush cycle.
  - mul_x*, out_y and out_tag keep their values; they are don't-care once out_valid=0.
- Latency and throughput:
  - Request accepted at edge k gives out_valid=1 after edge k+LATENCY.
  - LATENCY=2: accept at edge 0, out_valid high from edge 2.
  - With out_ready held 1, one op per LATENCY+1 cycles (DONE overlaps the next accept).
- Counter width: $clog2(LATENCY+1) bits, unsigned, no wrap; cnt never decrements below 0.
- Sampling and data path:
  - mul_y is sampled only on the EXEC edge with cnt==0.
  - The stage performs no arithmetic; mul_y is passed unmodified, including sign and clamped exponent.
- Invariant: out_valid==1 exactly when state==DONE.

Test Plan:
- Bench wraps fmul_issue with fmul connected (mul_x1/mul_x2 → x1/x2, y → mul_y), LATENCY=2, TAGW=6.
- Basic multiply: in_x1=0x40000000 (2.0), in_x2=0x40400000 (3.0), tag=5, out_ready=1 → out_valid after exactly 2 edges, out_y=0x40C00000, out_tag=5; then IDLE, busy=0.
- Back-to-back with stall:
  - Ops 0x3FC00000*0x3FC00000 (tag 1) and 0xBF800000*0x3F800000 (tag 2), out_ready=0 for 4 cycles.
  - Required: result 0x40100000/tag 1 held stable; in_ready=0 throughout the stall.
  - When out_ready rises, op 2 is accepted in the same cycle; then 0xBF800000/tag 2.
- Zero and overflow:
  - 0x00000000*0x40000000 → 0x00000000.
  - 0x7F000000*0x7F000000 → 0x7F800000.
  - 0x80000000*0x3F800000 → 0x80000000.
- Flush:
  - Assert flush during EXEC cnt=1 → next cycle IDLE, out_valid never rises.
  - Assert flush in DONE with out_ready=0 → out_valid drops next edge; in_valid during the flush cycle is not accepted.
- Async reset: drop rstn mid-EXEC between clock edges → out_valid, out_y, busy go 0 immediately; after release, a fresh op (2.0*3.0) completes normally.
- LATENCY=1 build: accept at edge 0 → out_valid after edge 1; sustained throughput one result per 2 cycles with out_ready=1.
